// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port fixed-latency memory
module mem_port_arbiter #(
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_dm,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} stateType;

   stateType   state, stateNext;
   logic [3:0] cnt;
   logic       isStore;
   logic       ifReqMasked, dmReqMasked;
   logic       grantIf, grantDm, done;

   // A port whose ready is high still shows its old request; it must not be regranted.
   assign ifReqMasked = if_req & ~if_ready;
   assign dmReqMasked = dm_req & ~dm_ready;
   assign done        = (state != IDLE) && (cnt == 4'd0);

   assign stall_if = if_req & ~if_ready;
   assign stall_dm = dm_req & ~dm_ready;
   assign busy     = (state != IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      grantIf   = 1'b0;
      grantDm   = 1'b0;
      case (state)
         IDLE: begin
            // Data access belongs to the older instruction, so it wins ties.
            if (dmReqMasked) begin
               stateNext = BUSY_DM;
               grantDm   = 1'b1;
            end else if (ifReqMasked) begin
               stateNext = BUSY_IF;
               grantIf   = 1'b1;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (cnt == 4'd0) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= 4'd0;
         isStore   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         if_ready  <= 1'b0;
         dm_rdata  <= '0;
         dm_ready  <= 1'b0;
      end else begin
         mem_en   <= grantIf | grantDm;
         mem_we   <= grantDm & dm_we;
         if_ready <= done && (state == BUSY_IF);
         dm_ready <= done && (state == BUSY_DM);
         if (grantIf || grantDm) begin
            cnt      <= 4'(MEM_LATENCY);
            mem_addr <= grantDm ? dm_addr : if_addr;
            isStore  <= grantDm & dm_we;
         end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (grantDm) begin
            mem_wdata <= dm_wdata;
         end
         if (done && (state == BUSY_IF)) begin
            if_rdata <= mem_rdata;
         end
         if (done && (state == BUSY_DM) && !isStore) begin
            dm_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int LAT = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        ifReq = 1'b0, dmReq = 1'b0, dmWe = 1'b0;
   logic [31:0] ifAddr = '0, dmAddr = '0, dmWdata = '0, memRdata = '0;
   logic [31:0] ifRdata, dmRdata, memAddr, memWdata;
   logic        ifReady, dmReady, memEn, memWe, stallIf, stallDm, busy;

   logic        if1Req = 1'b0;
   logic [31:0] if1Addr = '0, mem1Rdata = '0;
   logic [31:0] if1Rdata, dm1Rdata, mem1Addr, mem1Wdata;
   logic        if1Ready, dm1Ready, mem1En, mem1We, stall1If, stall1Dm, busy1;

   mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ready(ifReady),
      .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
      .dm_rdata(dmRdata), .dm_ready(dmReady),
      .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(memRdata), .stall_if(stallIf), .stall_dm(stallDm), .busy(busy)
   );

   mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
      .clock(clock), .reset_n(reset_n),
      .if_req(if1Req), .if_addr(if1Addr), .if_rdata(if1Rdata), .if_ready(if1Ready),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
      .dm_rdata(dm1Rdata), .dm_ready(dm1Ready),
      .mem_en(mem1En), .mem_we(mem1We), .mem_addr(mem1Addr), .mem_wdata(mem1Wdata),
      .mem_rdata(mem1Rdata), .stall_if(stall1If), .stall_dm(stall1Dm), .busy(busy1)
   );

   typedef struct {
      bit          dm;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          enCyc;
      int          rdyCyc;
      logic [31:0] rdata;
   } txnT;

   int          checks = 0, failures = 0, cyc = 0;
   bit          monOn = 1'b0, randOn = 1'b0;
   txnT         memQ[$], respQ[$];
   int          freeAt = 0, rdyIf = -1, rdyDm = -1, lastGrant = -1;
   logic [31:0] lastDm = '0;
   logic [31:0] memArr [logic [31:0]];
   logic [31:0] refMem [logic [31:0]];
   int          respCyc = -1;
   logic [31:0] respData = '0;
   int          exp1RdyCyc = -1;
   logic [31:0] exp1Data = '0;

   function automatic logic [31:0] defData(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   initial forever #5 clock = ~clock;
   initial forever begin @(posedge clock); cyc = cyc + 1; end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Transaction-level reference: serialised accesses, data first, just-served port masked.
   initial begin : model
      bit  mDm, mIf;
      txnT t;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            memQ.delete(); respQ.delete();
            freeAt = 0; rdyIf = -1; rdyDm = -1; lastGrant = -1; lastDm = '0;
         end else if (cyc >= freeAt) begin
            mDm = dmReq && (rdyDm != cyc);
            mIf = ifReq && (rdyIf != cyc);
            if (mDm || mIf) begin
               t.dm = mDm;
               t.we = mDm && dmWe;
               t.addr = mDm ? dmAddr : ifAddr;
               t.wdata = dmWdata;
               t.enCyc = cyc + 1;
               t.rdyCyc = cyc + LAT + 2;
               if (t.we) begin
                  refMem[t.addr] = t.wdata;
                  t.rdata = lastDm;
               end else begin
                  t.rdata = refMem.exists(t.addr) ? refMem[t.addr] : defData(t.addr);
                  if (t.dm) lastDm = t.rdata;
               end
               if (t.dm) rdyDm = t.rdyCyc; else rdyIf = t.rdyCyc;
               lastGrant = cyc;
               freeAt = t.rdyCyc;
               memQ.push_back(t);
               respQ.push_back(t);
            end
         end
      end
   end

   initial begin : monitor
      txnT t;
      forever begin
         @(negedge clock);
         if (monOn && !reset_n) begin
            chk("rst_if_ready", 64'(ifReady), 64'd0);
            chk("rst_dm_ready", 64'(dmReady), 64'd0);
            chk("rst_mem_en", 64'(memEn), 64'd0);
            chk("rst_l1_if_ready", 64'(if1Ready), 64'd0);
         end else if (monOn) begin
            if (memEn) begin
               if (memQ.size() == 0) begin
                  chk("unexpected_mem_en", 64'(memEn), 64'd0);
               end else begin
                  t = memQ.pop_front();
                  chk("mem_en_cycle", 64'(cyc), 64'(t.enCyc));
                  chk("mem_addr", 64'(memAddr), 64'(t.addr));
                  chk("mem_we", 64'(memWe), 64'(t.we));
                  if (t.we) chk("mem_wdata", 64'(memWdata), 64'(t.wdata));
               end
            end
            if (ifReady || dmReady) begin
               if (respQ.size() == 0) begin
                  chk("unexpected_ready", 64'(ifReady || dmReady), 64'd0);
               end else begin
                  t = respQ.pop_front();
                  chk("ready_port_dm", 64'(dmReady), 64'(t.dm));
                  chk("ready_cycle", 64'(cyc), 64'(t.rdyCyc));
                  chk("rdata", 64'(t.dm ? dmRdata : ifRdata), 64'(t.rdata));
               end
            end
            chk("both_ready", 64'(ifReady && dmReady), 64'd0);
            chk("we_without_en", 64'(memWe && !memEn), 64'd0);
            chk("stall_if", 64'(stallIf), 64'(ifReq && !ifReady));
            chk("stall_dm", 64'(stallDm), 64'(dmReq && !dmReady));
            chk("busy", 64'(busy), 64'(cyc > lastGrant && cyc < freeAt));
            chk("l1_if_ready", 64'(if1Ready), 64'(cyc == exp1RdyCyc));
            if (if1Ready) chk("l1_if_rdata", 64'(if1Rdata), 64'(exp1Data));
         end
      end
   end

   // Memory models: stores land in memArr, reads return data only in the valid cycle.
   initial forever begin
      @(negedge clock);
      if (!reset_n) begin
         respCyc = -1;
      end else if (memEn) begin
         if (memWe) memArr[memAddr] = memWdata;
         else begin
            respCyc = cyc + LAT;
            respData = memArr.exists(memAddr) ? memArr[memAddr] : defData(memAddr);
         end
      end
   end
   initial forever begin
      @(posedge clock); #1;
      memRdata = (cyc == respCyc) ? respData : $urandom;
   end
   initial begin : mem1
      bit          en1Seen;
      logic [31:0] a1;
      en1Seen = 1'b0; a1 = '0;
      forever begin
         @(negedge clock); en1Seen = mem1En; a1 = mem1Addr;
         @(posedge clock); #1;
         mem1Rdata = en1Seen ? defData(a1) : $urandom;
      end
   end

   // Requesters: drop after the ready cycle; in random mode issue and scramble operands.
   initial begin : drvIf
      logic r;
      forever begin
         @(negedge clock); r = ifReady;
         @(posedge clock); #1;
         if (ifReq && r === 1'b1) ifReq = 1'b0;
         if (randOn) begin
            if (!ifReq && $urandom_range(0, 3) != 0) ifReq = 1'b1;
            ifAddr = 32'h00400000 + 32'($urandom_range(0, 15)) * 4;
         end
      end
   end
   initial begin : drvDm
      logic r;
      forever begin
         @(negedge clock); r = dmReady;
         @(posedge clock); #1;
         if (dmReq && r === 1'b1) dmReq = 1'b0;
         if (randOn) begin
            if (!dmReq && $urandom_range(0, 3) != 0) dmReq = 1'b1;
            dmAddr = 32'h10010000 + 32'($urandom_range(0, 7)) * 4;
            dmWe = 1'($urandom_range(0, 1));
            dmWdata = $urandom;
         end
      end
   end

   task automatic waitIdle(input string name);
      int n = 0;
      while ((ifReq || dmReq) && n < 60) begin
         @(posedge clock); #2;
         n++;
      end
      chk(name, 64'(ifReq || dmReq), 64'd0);
   endtask

   task automatic chkRst();
      chk("rst_mem_en_now", 64'(memEn), 64'd0);
      chk("rst_mem_we_now", 64'(memWe), 64'd0);
      chk("rst_mem_addr_now", 64'(memAddr), 64'd0);
      chk("rst_mem_wdata_now", 64'(memWdata), 64'd0);
      chk("rst_if_rdata_now", 64'(ifRdata), 64'd0);
      chk("rst_if_ready_now", 64'(ifReady), 64'd0);
      chk("rst_dm_rdata_now", 64'(dmRdata), 64'd0);
      chk("rst_dm_ready_now", 64'(dmReady), 64'd0);
      chk("rst_busy_now", 64'(busy), 64'd0);
      chk("rst_stall_if_now", 64'(stallIf), 64'(ifReq));
      chk("rst_stall_dm_now", 64'(stallDm), 64'(dmReq));
   endtask

   task automatic runFetch1(input logic [31:0] a);
      @(posedge clock); #2;
      if1Req = 1'b1; if1Addr = a;
      exp1RdyCyc = cyc + 3; exp1Data = defData(a);
      while (cyc <= exp1RdyCyc) begin @(posedge clock); #2; end
      if1Req = 1'b0;
   endtask

   initial begin
      memArr[32'h00400000] = 32'h2402000A; refMem[32'h00400000] = 32'h2402000A;
      memArr[32'h10010004] = 32'h00000007; refMem[32'h10010004] = 32'h00000007;

      #12;
      reset_n = 1'b0; ifReq = 1'b1;
      #1 chkRst();
      ifReq = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1; monOn = 1'b1;

      @(posedge clock); #2;
      ifReq = 1'b1; ifAddr = 32'h00400000;
      waitIdle("fetch_done");

      @(posedge clock); #2;
      ifReq = 1'b1; ifAddr = 32'h00400004;
      dmReq = 1'b1; dmWe = 1'b0; dmAddr = 32'h10010004;
      waitIdle("simultaneous_done");

      @(posedge clock); #2;
      dmReq = 1'b1; dmWe = 1'b1; dmAddr = 32'h10010000; dmWdata = 32'hDEADBEEF;
      waitIdle("store_done");

      runFetch1(32'h00400040);

      randOn = 1'b1;
      repeat (800) @(posedge clock);
      #2 randOn = 1'b0;
      waitIdle("random_done");

      @(posedge clock); #2;
      ifReq = 1'b1; ifAddr = 32'h00400010;
      if1Req = 1'b1; if1Addr = 32'h00400020; exp1RdyCyc = -1;
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b0; ifReq = 1'b0; if1Req = 1'b0;
      #1 chkRst();
      repeat (3) @(posedge clock);
      #2 reset_n = 1'b1;
      @(posedge clock); #2;
      ifReq = 1'b1; ifAddr = 32'h00400000;
      runFetch1(32'h00400044);
      waitIdle("post_reset_fetch_done");

      repeat (8) @(posedge clock);
      #2;
      chk("mem_queue_drained", 64'(memQ.size()), 64'd0);
      chk("resp_queue_drained", 64'(respQ.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (data loads and stores).
- Grants one access at a time and sequences the memory strobe.
- Returns read data and a one-cycle ready pulse to the winning port.
- Generates per-port stall outputs that feed the hazard unit's StallF/StallD/FlushE logic.

Parameters:
- MEM_LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal values are 1 to 15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  instruction word; valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for the fetch port
- dm_req  in  1  data request; held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data; valid while dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for the data port
- mem_en  out  1  one-cycle access strobe to memory
- mem_we  out  1  write enable; qualified by mem_en
- mem_addr  out  ADDR_W  latched access address
- mem_wdata  out  DATA_W  latched store data
- mem_rdata  in  DATA_W  memory read data; valid MEM_LATENCY cycles after the mem_en cycle
- stall_if  out  1  stall request for the fetch port: if_req & ~if_ready (combinational)
- stall_dm  out  1  stall request for the data port: dm_req & ~dm_ready (combinational)
- busy  out  1  1 in BUSY_IF or BUSY_DM

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, cnt=0, and every registered output is 0 (mem_en, mem_we, mem_addr, mem_wdata, if_rdata, if_ready, dm_rdata, dm_ready).
- Reset mid-transaction: the transaction is abandoned, no ready pulse is produced, and the late memory response is ignored.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- Request masking: in any cycle where x_ready=1, x_req is ignored. The requester still holds its old request that cycle, so it must not be regranted.
- IDLE arbitration, using the masked requests:
  - dm_req wins → BUSY_DM.
  - else if_req → BUSY_IF.
  - else stay in IDLE.
  - Data has fixed priority: it belongs to the older instruction.
- Grant edge (end of cycle 0):
  - latch addr into mem_addr; for data, also latch dm_we and dm_wdata into mem_we and mem_wdata;
  - set cnt=MEM_LATENCY;
  - assert mem_en (and mem_we if a store) for cycle 1 only.
  - Port inputs are not sampled again until completion; changes while busy are ignored.
- BUSY states:
  - cnt decrements every cycle.
  - When cnt==0 (cycle 1+MEM_LATENCY), the next edge:
    - captures mem_rdata into the granted port's rdata (loads and fetches only; dm_rdata holds its value on stores);
    - pulses that port's ready for exactly one cycle (cycle 2+MEM_LATENCY);
    - returns to IDLE.
- Latency: request seen in cycle 0 → ready in cycle MEM_LATENCY+2. Back-to-back accesses have a throughput of one per MEM_LATENCY+2 cycles.
- Fairness: the completion IDLE cycle masks the just-served port, so a waiting port is granted at that edge. Fetch cannot starve behind a continuous data stream; grants alternate.
- Both ready outputs are never 1 in the same cycle.
- mem_en is never asserted outside the cycle after a grant.
- mem_we=0 whenever mem_en=0.

Test Plan:
- Reset: assert reset_n=0 asynchronously between edges → all outputs 0 immediately, busy=0, stall_if = if_req.
- Single fetch, MEM_LATENCY=2: if_req=1, if_addr=0x00400000 in cycle 0; memory drives 0x2402000A in cycle 3 → mem_en=1 with mem_addr=0x00400000 in cycle 1 only; if_ready=1 with if_rdata=0x2402000A in cycle 4 only; stall_if=1 in cycles 0–3.
- Store: dm_req=1, dm_we=1, dm_addr=0x10010000, dm_wdata=0xDEADBEEF → mem_en=mem_we=1 with those values in cycle 1; dm_ready in cycle 4; dm_rdata unchanged from its prior value.
- Simultaneous requests: if_req and dm_req (load from 0x10010004, memory returns 0x00000007) both high in cycle 0 → dm_ready with 0x00000007 in cycle 4; fetch mem_en in cycle 5; if_ready in cycle 8; stall_if high in cycles 0–7.
- Fairness: dm_req held high continuously (new address after each ready) with if_req high → grant order DM, IF, DM, IF; ready pulses in cycles 4, 8, 12, 16.
- Reset mid-operation: reset_n=0 in cycle 2 of a fetch, released in cycle 5, no new request → no if_ready ever. A new fetch starting in cycle 6 completes in cycle 10. Repeat with MEM_LATENCY=1: ready in cycle 3 of a transaction.
